vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have port: Clk  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-002 The block SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have port: vga_clk  output  1  pixel clock, Clk/2, drives pixel consumers.
REQ-004 The block SHALL have port: hs  output  1  horizontal sync, active-low.
REQ-005 The block SHALL have port: vs  output  1  vertical sync, active-low.
REQ-006 The block SHALL have port: blank  output  1  display enable; 1 = visible pixel, 0 = blanking.
REQ-007 The block SHALL have port: DrawX  output  10  current horizontal pixel count.
REQ-008 The block SHALL have port: DrawY  output  10  current vertical line count.
REQ-009 The block SHALL have port: frame_start  output  1  one-Clk pulse at the start of each frame.
REQ-010 The block SHALL have port: frame_count  output  16  completed-frame counter; see Configuration.
REQ-011 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.

Function
REQ-012 The block SHALL keep a toggle register that inverts every Clk cycle and drives vga_clk; pixel enable (pix_en) SHALL be the Clk cycles where the toggle register is 1.
REQ-013 On each pix_en, the horizontal counter hc SHALL advance 0..799 and wrap to 0; it SHALL hold otherwise.
REQ-014 The vertical counter vc SHALL advance 0..524 only on a pix_en where hc wraps 799->0; at vc=524 it SHALL wrap to 0.
REQ-015 DrawX SHALL equal hc, and DrawY SHALL equal vc; the 10-bit counters SHALL never exceed 799/524.
REQ-016 hs SHALL be 0 exactly while hc is in 656..751 inclusive, else 1.
REQ-017 vs SHALL be 0 exactly while vc is in 490..491 inclusive, else 1.
REQ-018 blank SHALL be 1 exactly while hc<640 and vc<480, else 0.
REQ-019 hs, vs and blank SHALL be registered and cycle-aligned with DrawX/DrawY, so the same Clk edge updates all of them; there SHALL be no combinational path from counters to outputs.
REQ-020 frame_start SHALL be 1 for exactly one Clk cycle: the cycle in which hc and vc become 0 together after a wrap.
REQ-021 frame_start SHALL NOT assert on reset release.
REQ-022 The frame period SHALL be 800*525 pix_en = 840000 Clk cycles.

Reset
REQ-023 While reset_n=0, the outputs SHALL be: toggle register/vga_clk=0, hc=vc=0, hs=1, vs=1, blank=0, frame_start=0, frame_count=0.
REQ-024 Reset assertion mid-line or mid-frame SHALL take effect immediately (asynchronously) with no completion of the current line.
REQ-025 On the first Clk edge after reset_n rises, blank SHALL become 1 because (0,0) is visible.
REQ-026 On the second Clk edge after reset_n rises, the first pix_en SHALL occur; hc SHALL reach 1 on the edge after that pix_en cycle.

Configuration
REQ-027 With macro VGA_FRAME_COUNT_EN defined, frame_count SHALL increment by 1, wrapping 65535->0, on the same edge that asserts frame_start.
REQ-028 Without VGA_FRAME_COUNT_EN, frame_count SHALL be constant 0 with no counter logic; all other behaviour SHALL be identical.

Verification
REQ-029 Release reset, count Clk edges -> vga_clk has period 2 Clk; first frame_start occurs exactly 840000 Clk cycles after the first pix_en.
REQ-030 Run one line, sample on pix_en -> hs=0 for DrawX 656..751 (96 pixels), 1 elsewhere; blank=1 for DrawX 0..639 only.
REQ-031 Run a full frame -> vs=0 for DrawY 490..491 (1600 pixel clocks); blank=0 for all DrawY 480..524; DrawY wraps 524->0 with DrawX=0.
REQ-032 Assert reset_n=0 at DrawX=300, DrawY=200 -> all outputs go to reset values without waiting for a Clk edge; after release, counting restarts from (0,0).
REQ-033 With VGA_FRAME_COUNT_EN, run 3 frames -> frame_count=3, with each increment coincident with a frame_start; without the macro, frame_count stays 0.
REQ-034 Check every cycle -> DrawX<=799, DrawY<=524, and hs/vs/blank always match REQ-016..018 for the current DrawX/DrawY.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// 640x480 @ 60 Hz VGA raster timing generator running from a 50 MHz system
// clock. A divide-by-two toggle produces the 25 MHz pixel clock. The same
// toggle is used as the pixel enable that steps the horizontal and vertical
// counters.
//
// Ports
//   Clk          in   1  system clock; all logic on its rising edge
//   reset_n      in   1  asynchronous active-low reset
//   vga_clk      out  1  pixel clock, Clk/2
//   hs           out  1  horizontal sync, active-low
//   vs           out  1  vertical sync, active-low
//   blank        out  1  1 = visible pixel, 0 = blanking interval
//   DrawX        out 10  current horizontal pixel count (0..799)
//   DrawY        out 10  current vertical line count (0..524)
//   frame_start  out  1  one-Clk pulse when the raster returns to (0,0)
//   frame_count  out 16  completed-frame counter
//
// Optional feature
//   VGA_FRAME_COUNT_EN  when defined, frame_count increments (wrapping) on
//                       every frame_start. When undefined, frame_count is
//                       tied to zero and no counter is built.
//
// The timing parameters default to standard 640x480 VGA. They are exposed
// so that the raster geometry can be changed without touching the logic.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned H_SYNC_END   = 751,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned V_SYNC_END   = 491,
  parameter int unsigned V_TOTAL      = 525
) (
  input  logic        Clk,
  input  logic        reset_n,
  output logic        vga_clk,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
  localparam logic [9:0] H_SE   = 10'(H_SYNC_END);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] V_SS   = 10'(V_SYNC_START);
  localparam logic [9:0] V_SE   = 10'(V_SYNC_END);

  logic       toggle_q, toggle_d;
  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_q, blank_d;
  logic       frame_start_q, frame_start_d;
  logic       pix_en;
  logic       h_wrap;
  logic       v_wrap;

  // Next-state logic. The sync and blank flags are decoded from the *next*
  // counter values so that all flags land on the same edge as DrawX/DrawY.
  // This keeps the registered outputs aligned with the counters while still
  // avoiding any combinational path from the counters to the pins.
  always_comb begin
    toggle_d      = ~toggle_q;
    pix_en        = toggle_q;
    h_wrap        = (hc_q == H_LAST);
    v_wrap        = (vc_q == V_LAST);
    hc_d          = hc_q;
    vc_d          = vc_q;
    frame_start_d = 1'b0;

    if (pix_en) begin
      if (h_wrap) begin
        hc_d = '0;
        if (v_wrap) begin
          vc_d          = '0;
          frame_start_d = 1'b1;
        end else begin
          vc_d = vc_q + 10'd1;
        end
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end

    hs_d    = ~((hc_d >= H_SS) && (hc_d <= H_SE));
    vs_d    = ~((vc_d >= V_SS) && (vc_d <= V_SE));
    blank_d = (hc_d < H_VIS) && (vc_d < V_VIS);
  end

  // Raster state. Reset puts the raster at (0,0) with the syncs idle and
  // blanking asserted. The first edge after release then raises blank,
  // because (0,0) is a visible pixel.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q      <= 1'b0;
      hc_q          <= '0;
      vc_q          <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      toggle_q      <= toggle_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // The frame counter steps on the same edge that raises frame_start and
  // wraps naturally at 16 bits.
  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_start_d) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = '0;
`endif

  assign vga_clk     = toggle_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen.
// Instance "a" uses the standard 640x480 geometry and exercises the clock,
// line timing and mid-line reset. Instance "b" uses a shrunken raster so that
// several whole frames (vertical sync, frame wrap, frame_start and
// frame_count) fit in a short run.
// Expected outputs come from a bench-side raster model. They are queued on
// each clock edge and compared when the DUT outputs settle.
module tb_vga_timing_gen;

  localparam int SH_TOTAL = 40;
  localparam int SH_VIS   = 32;
  localparam int SH_S0    = 34;
  localparam int SH_S1    = 37;
  localparam int SV_TOTAL = 12;
  localparam int SV_VIS   = 8;
  localparam int SV_S0    = 9;
  localparam int SV_S1    = 10;

  typedef struct packed {
    logic        tog;
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic [15:0] fc;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        blank;
  } mdl_t;

  typedef struct packed {
    logic        vclk;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        fs;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] fc;
  } obs_t;

  logic        Clk   = 1'b0;
  logic        rst_a = 1'b0;
  logic        rst_b = 1'b0;

  logic        vclk_a, hs_a, vs_a, blank_a, fs_a;
  logic [9:0]  x_a, y_a;
  logic [15:0] fc_a;
  logic        vclk_b, hs_b, vs_b, blank_b, fs_b;
  logic [9:0]  x_b, y_b;
  logic [15:0] fc_b;

  int   checks   = 0;
  int   failures = 0;
  obs_t exp_q[$];
  mdl_t ma;
  mdl_t mb;

  vga_timing_gen dut_a (
    .Clk         (Clk),
    .reset_n     (rst_a),
    .vga_clk     (vclk_a),
    .hs          (hs_a),
    .vs          (vs_a),
    .blank       (blank_a),
    .DrawX       (x_a),
    .DrawY       (y_a),
    .frame_start (fs_a),
    .frame_count (fc_a)
  );

  vga_timing_gen #(
    .H_VISIBLE    (SH_VIS),
    .H_SYNC_START (SH_S0),
    .H_SYNC_END   (SH_S1),
    .H_TOTAL      (SH_TOTAL),
    .V_VISIBLE    (SV_VIS),
    .V_SYNC_START (SV_S0),
    .V_SYNC_END   (SV_S1),
    .V_TOTAL      (SV_TOTAL)
  ) dut_b (
    .Clk         (Clk),
    .reset_n     (rst_b),
    .vga_clk     (vclk_b),
    .hs          (hs_b),
    .vs          (vs_b),
    .blank       (blank_b),
    .DrawX       (x_b),
    .DrawY       (y_b),
    .frame_start (fs_b),
    .frame_count (fc_b)
  );

  always #10 Clk = ~Clk;

  // Watchdog so the run always terminates.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m       = '0;
    m.hs    = 1'b1;
    m.vs    = 1'b1;
    m.blank = 1'b0;
    return m;
  endfunction

  // One Clk edge of the raster, written straight from the timing rules.
  function automatic mdl_t mdl_step(mdl_t m, int ht, int hv, int hs0, int hs1,
                                    int vt, int vv, int vs0, int vs1);
    mdl_t n;
    n    = m;
    n.fs = 1'b0;
    if (m.tog) begin
      if (int'(m.hc) == ht - 1) begin
        n.hc = 10'd0;
        if (int'(m.vc) == vt - 1) begin
          n.vc = 10'd0;
          n.fs = 1'b1;
        end else begin
          n.vc = m.vc + 10'd1;
        end
      end else begin
        n.hc = m.hc + 10'd1;
      end
    end
`ifdef VGA_FRAME_COUNT_EN
    if (n.fs) n.fc = m.fc + 16'd1;
`endif
    n.tog   = ~m.tog;
    n.hs    = !((int'(n.hc) >= hs0) && (int'(n.hc) <= hs1));
    n.vs    = !((int'(n.vc) >= vs0) && (int'(n.vc) <= vs1));
    n.blank = (int'(n.hc) < hv) && (int'(n.vc) < vv);
    return n;
  endfunction

  function automatic mdl_t step_a(mdl_t m);
    return mdl_step(m, 800, 640, 656, 751, 525, 480, 490, 491);
  endfunction

  function automatic mdl_t step_b(mdl_t m);
    return mdl_step(m, SH_TOTAL, SH_VIS, SH_S0, SH_S1, SV_TOTAL, SV_VIS, SV_S0, SV_S1);
  endfunction

  function automatic obs_t mdl_obs(mdl_t m);
    return {m.tog, m.hs, m.vs, m.blank, m.fs, m.hc, m.vc, m.fc};
  endfunction

  function automatic obs_t obs_a();
    return {vclk_a, hs_a, vs_a, blank_a, fs_a, x_a, y_a, fc_a};
  endfunction

  function automatic obs_t obs_b();
    return {vclk_b, hs_b, vs_b, blank_b, fs_b, x_b, y_b, fc_b};
  endfunction

  // Both instances held in reset must show the reset values.
  task automatic test_reset();
    obs_t e, o;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge Clk);
    ma = mdl_reset();
    mb = mdl_reset();
    exp_q.push_back(mdl_obs(ma));
    exp_q.push_back(mdl_obs(mb));
    e = exp_q.pop_front();
    o = obs_a();
    checks++;
    if (o !== e) begin
      failures++;
      $display("[TB] FAIL reset_a: got %h required %h", o, e);
    end
    e = exp_q.pop_front();
    o = obs_b();
    checks++;
    if (o !== e) begin
      failures++;
      $display("[TB] FAIL reset_b: got %h required %h", o, e);
    end
  endtask

  // Release reset on instance a and watch the pixel clock and first pixels.
  task automatic test_clock();
    obs_t e, o;
    logic last;
    int   toggles;
    toggles = 0;
    last    = 1'b0;
    @(negedge Clk) rst_a = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge Clk);
      ma = step_a(ma);
      exp_q.push_back(mdl_obs(ma));
      #1;
      e = exp_q.pop_front();
      o = obs_a();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL clock_cycle %0d: got %h required %h", i, o, e);
      end
      if (vclk_a !== last) toggles++;
      last = vclk_a;
      if (i == 1) begin
        checks++;
        if (blank_a !== 1'b1) begin
          failures++;
          $display("[TB] FAIL blank_first_edge: got %b required 1", blank_a);
        end
      end
      if (i == 2) begin
        checks++;
        if (x_a !== 10'd1) begin
          failures++;
          $display("[TB] FAIL first_pix_en: DrawX got %0d required 1", x_a);
        end
      end
    end
    checks++;
    if (toggles != 20) begin
      failures++;
      $display("[TB] FAIL vga_clk_period: toggles got %0d required 20", toggles);
    end
  endtask

  // Run through all of line 1 and measure the hsync and visible windows.
  task automatic test_line();
    obs_t e, o;
    int   hs_low, vis, min_x, max_x;
    hs_low = 0;
    vis    = 0;
    min_x  = 1023;
    max_x  = 0;
    for (int i = 0; i < 3300; i++) begin
      @(posedge Clk);
      ma = step_a(ma);
      exp_q.push_back(mdl_obs(ma));
      #1;
      e = exp_q.pop_front();
      o = obs_a();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL line_cycle %0d: got %h required %h", i, o, e);
      end
      if (y_a == 10'd1) begin
        if (hs_a == 1'b0) begin
          hs_low++;
          if (int'(x_a) < min_x) min_x = int'(x_a);
          if (int'(x_a) > max_x) max_x = int'(x_a);
        end
        if (blank_a == 1'b1) vis++;
      end
    end
    checks++;
    if (hs_low != 192) begin
      failures++;
      $display("[TB] FAIL hs_width: Clk cycles got %0d required 192", hs_low);
    end
    checks++;
    if (min_x != 656 || max_x != 751) begin
      failures++;
      $display("[TB] FAIL hs_window: got %0d..%0d required 656..751", min_x, max_x);
    end
    checks++;
    if (vis != 1280) begin
      failures++;
      $display("[TB] FAIL visible_width: Clk cycles got %0d required 1280", vis);
    end
  endtask

  // Assert reset mid-line between clock edges; outputs must clear at once.
  // After release, the raster restarts from (0,0).
  task automatic test_reset_midline();
    obs_t e, o;
    bit   found;
    found = 1'b0;
    for (int i = 0; i < 1700 && !found; i++) begin
      @(posedge Clk);
      ma = step_a(ma);
      exp_q.push_back(mdl_obs(ma));
      #1;
      e = exp_q.pop_front();
      o = obs_a();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL midline_cycle %0d: got %h required %h", i, o, e);
      end
      if (ma.hc == 10'd300) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL reach_x300: model never reached DrawX 300");
    end
    rst_a = 1'b0;
    #2;
    ma = mdl_reset();
    exp_q.push_back(mdl_obs(ma));
    e = exp_q.pop_front();
    o = obs_a();
    checks++;
    if (o !== e) begin
      failures++;
      $display("[TB] FAIL async_reset: got %h required %h", o, e);
    end
    @(negedge Clk) rst_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge Clk);
      ma = step_a(ma);
      exp_q.push_back(mdl_obs(ma));
      #1;
      e = exp_q.pop_front();
      o = obs_a();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL restart_cycle %0d: got %h required %h", i, o, e);
      end
      if (i == 2) begin
        checks++;
        if (x_a !== 10'd1 || y_a !== 10'd0) begin
          failures++;
          $display("[TB] FAIL restart_origin: got (%0d,%0d) required (1,0)", x_a, y_a);
        end
      end
    end
  endtask

  // Three whole frames on the shrunken raster: vsync, wrap, frame pulses.
  task automatic test_frame();
    obs_t e, o;
    int   fs_cnt, first_fs, vs_low;
    logic [15:0] fc_exp;
    fs_cnt   = 0;
    first_fs = -1;
    vs_low   = 0;
    @(negedge Clk);
    rst_a = 1'b0;
    rst_b = 1'b1;
    for (int i = 1; i <= 2900; i++) begin
      @(posedge Clk);
      mb = step_b(mb);
      exp_q.push_back(mdl_obs(mb));
      #1;
      e = exp_q.pop_front();
      o = obs_b();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL frame_cycle %0d: got %h required %h", i, o, e);
      end
      if (vs_b == 1'b0) vs_low++;
      if (fs_b == 1'b1) begin
        fs_cnt++;
        if (first_fs < 0) first_fs = i;
`ifdef VGA_FRAME_COUNT_EN
        fc_exp = 16'(fs_cnt);
`else
        fc_exp = 16'd0;
`endif
        checks++;
        if (fc_b !== fc_exp) begin
          failures++;
          $display("[TB] FAIL fc_at_frame_start: got %0d required %0d", fc_b, fc_exp);
        end
      end
    end
    checks++;
    if (fs_cnt != 3) begin
      failures++;
      $display("[TB] FAIL frame_start_count: got %0d required 3", fs_cnt);
    end
    checks++;
    if (first_fs != 2 * SH_TOTAL * SV_TOTAL) begin
      failures++;
      $display("[TB] FAIL frame_period: first pulse at edge %0d required %0d",
               first_fs, 2 * SH_TOTAL * SV_TOTAL);
    end
    checks++;
    if (vs_low != 3 * 2 * SH_TOTAL * 2) begin
      failures++;
      $display("[TB] FAIL vs_width: Clk cycles got %0d required %0d",
               vs_low, 3 * 2 * SH_TOTAL * 2);
    end
`ifdef VGA_FRAME_COUNT_EN
    fc_exp = 16'd3;
`else
    fc_exp = 16'd0;
`endif
    checks++;
    if (fc_b !== fc_exp) begin
      failures++;
      $display("[TB] FAIL frame_count_final: got %0d required %0d", fc_b, fc_exp);
    end
  endtask

  initial begin
    test_reset();
    test_clock();
    test_line();
    test_reset_midline();
    test_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
